// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master / one-slave arbiter for the 32-bit read/write/waitrequest bus.
//   M0 is the CPU, M1 is a loader/debug master; both share one RAM slave.
//   Once a stalled transfer starts, the bus is locked to that master until the
//   transfer completes (or the master drops its strobe). Long slave stalls of
//   the owned transfer raise a sticky timeout flag.
//
// Parameters
//   RR_MODE         0 = fixed priority (M0 wins ties), 1 = round-robin on ties
//   TIMEOUT_CYCLES  stall cycles of an owned transfer before timeout_err sets
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   mX_address/read/write/
//   writedata/byteenable          master X request side (X = 0, 1)
//   mX_readdata                   slave read data, broadcast to both masters
//   mX_waitrequest                stall to master X (1 when not selected)
//   s_address/read/write/
//   writedata/byteenable          request forwarded to the RAM
//   s_readdata, s_waitrequest     RAM response
//   grant                         one-hot current connection {M1,M0}
//   timeout_err                   sticky stall-timeout flag
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter bit RR_MODE        = 1'b1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last, w_last_nxt;         // last master served: 0 = M0, 1 = M1
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;

  logic w_req0, w_req1;
  logic w_sel_valid;                            // some master is connected this cycle
  logic w_sel_m1;                               // connected master is M1
  logic w_sel_req;                              // connected master's strobe

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // ---------------------------------------------------------------------------
  // Selection: owner wins while locked; otherwise arbitrate among requesters.
  // Reset forces "no selection" so nothing reaches the RAM while reset is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_sel_valid = 1'b0;
    w_sel_m1    = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_OWN0: w_sel_valid = 1'b1;
        ST_OWN1: begin
          w_sel_valid = 1'b1;
          w_sel_m1    = 1'b1;
        end
        default: begin
          if (w_req0 && w_req1) begin
            w_sel_valid = 1'b1;
            // Round-robin serves whoever was not served last.
            w_sel_m1    = RR_MODE ? ~r_last : 1'b0;
          end else if (w_req0) begin
            w_sel_valid = 1'b1;
          end else if (w_req1) begin
            w_sel_valid = 1'b1;
            w_sel_m1    = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_sel_req = w_sel_m1 ? w_req1 : w_req0;

  // ---------------------------------------------------------------------------
  // Bus multiplexer.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (w_sel_valid) begin
      if (w_sel_m1) begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end else begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
    end
  end

  assign grant       = {w_sel_valid & w_sel_m1, w_sel_valid & ~w_sel_m1};
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign timeout_err = r_timeout_err;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_last_nxt        = r_last;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_timeout_err_nxt = r_timeout_err;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          if (s_waitrequest) begin
            // First stall cycle: lock the bus and count this cycle.
            w_state_nxt    = w_sel_m1 ? ST_OWN1 : ST_OWN0;
            w_wait_cnt_nxt = CNT_W'(1);
          end else begin
            w_last_nxt = w_sel_m1;
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_sel_req) begin
          // Owner abandoned its transfer; release without crediting it.
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (!s_waitrequest) begin
          w_state_nxt    = ST_IDLE;
          w_last_nxt     = w_sel_m1;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != CNT_MAX) begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_wait_cnt_nxt == CNT_MAX) begin
      w_timeout_err_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;       // M0 wins the first round-robin tie
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Two arbiter instances share one set of master stimuli:
//     dut0: RR_MODE=1, TIMEOUT_CYCLES=4
//     dut1: RR_MODE=0, TIMEOUT_CYCLES=64
//   Each instance has its own RAM. A transaction-level reference model (owner,
//   last served, stall count, word memory) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_waitrequest;

  logic [31:0] d_m0_readdata [2];
  logic [31:0] d_m1_readdata [2];
  logic        d_m0_wait     [2];
  logic        d_m1_wait     [2];
  logic [31:0] d_s_address   [2];
  logic        d_s_read      [2];
  logic        d_s_write     [2];
  logic [31:0] d_s_writedata [2];
  logic [3:0]  d_s_be        [2];
  logic [31:0] d_s_readdata  [2];
  logic [1:0]  d_grant       [2];
  logic        d_timeout     [2];

  mem_bus_arbiter #(.RR_MODE(1'b1), .TIMEOUT_CYCLES(4)) u_dut_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(d_m0_readdata[0]), .m0_waitrequest(d_m0_wait[0]),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(d_m1_readdata[0]), .m1_waitrequest(d_m1_wait[0]),
    .s_address(d_s_address[0]), .s_read(d_s_read[0]), .s_write(d_s_write[0]),
    .s_writedata(d_s_writedata[0]), .s_byteenable(d_s_be[0]),
    .s_readdata(d_s_readdata[0]), .s_waitrequest(s_waitrequest),
    .grant(d_grant[0]), .timeout_err(d_timeout[0])
  );

  mem_bus_arbiter #(.RR_MODE(1'b0), .TIMEOUT_CYCLES(64)) u_dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(d_m0_readdata[1]), .m0_waitrequest(d_m0_wait[1]),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(d_m1_readdata[1]), .m1_waitrequest(d_m1_wait[1]),
    .s_address(d_s_address[1]), .s_read(d_s_read[1]), .s_write(d_s_write[1]),
    .s_writedata(d_s_writedata[1]), .s_byteenable(d_s_be[1]),
    .s_readdata(d_s_readdata[1]), .s_waitrequest(s_waitrequest),
    .grant(d_grant[1]), .timeout_err(d_timeout[1])
  );

  // ---------------------------------------------------------------- RAM slaves
  logic [31:0] ram [2][4096];

  assign d_s_readdata[0] = ram[0][d_s_address[0][13:2]];
  assign d_s_readdata[1] = ram[1][d_s_address[1][13:2]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (d_s_write[d] && !s_waitrequest) begin
        for (int b = 0; b < 4; b++) begin
          if (d_s_be[d][b]) ram[d][d_s_address[d][13:2]][8*b +: 8] <= d_s_writedata[d][8*b +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] seed(int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
  endfunction

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [69:0] act, logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [31:0] a0, d0;
    logic [3:0]  be0;
    bit          r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  be1;
    bit          stall;
  } stim_t;

  function automatic stim_t mk(bit rst, bit r0, bit w0, logic [31:0] a0, logic [31:0] d0,
                               logic [3:0] be0, bit r1, bit w1, logic [31:0] a1,
                               logic [31:0] d1, logic [3:0] be1, bit stall);
    stim_t s;
    s.rst = rst; s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0; s.be0 = be0;
    s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1; s.be1 = be1; s.stall = stall;
    return s;
  endfunction

  // ---------------------------------------------------------------- reference model
  // Per instance: owner (-1 none), last master served, stall count, sticky error.
  int          m_own  [2];
  int          m_last [2];
  int          m_wcnt [2];
  bit          m_terr [2];
  logic [31:0] m_mem  [2][4096];

  function automatic bit rr_of(int d);
    return d == 0;
  endfunction

  function automatic int to_of(int d);
    return (d == 0) ? 4 : 64;
  endfunction

  task automatic model_reset(int d);
    m_own[d] = -1; m_last[d] = 1; m_wcnt[d] = 0; m_terr[d] = 1'b0;
  endtask

  function automatic int m_select(int d, bit rq0, bit rq1, bit rst);
    if (rst)            return -1;
    if (m_own[d] >= 0)  return m_own[d];
    if (rq0 && rq1)     return rr_of(d) ? 1 - m_last[d] : 0;
    if (rq0)            return 0;
    if (rq1)            return 1;
    return -1;
  endfunction

  task automatic model_cycle(int d, stim_t s);
    int          sel, idx;
    bit          rq0, rq1, rq, rd, wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [1:0]  eg;
    logic [69:0] eb;
    rq0 = s.r0 | s.w0;
    rq1 = s.r1 | s.w1;
    sel = m_select(d, rq0, rq1, s.rst);
    rd = 0; wr = 0; a = '0; wd = '0; be = '0; eg = 2'b00; eb = '0;
    if (sel == 0) begin
      rd = s.r0; wr = s.w0; a = s.a0; wd = s.d0; be = s.be0; eg = 2'b01;
    end else if (sel == 1) begin
      rd = s.r1; wr = s.w1; a = s.a1; wd = s.d1; be = s.be1; eg = 2'b10;
    end
    if (sel >= 0) eb = {rd, wr, be, a, wd};
    check($sformatf("dut%0d grant", d), 70'(d_grant[d]), 70'(eg));
    check($sformatf("dut%0d s_bus", d),
          {d_s_read[d], d_s_write[d], d_s_be[d], d_s_address[d], d_s_writedata[d]}, eb);
    check($sformatf("dut%0d m0_waitrequest", d), 70'(d_m0_wait[d]), 70'((sel == 0) ? s.stall : 1'b1));
    check($sformatf("dut%0d m1_waitrequest", d), 70'(d_m1_wait[d]), 70'((sel == 1) ? s.stall : 1'b1));
    check($sformatf("dut%0d timeout_err", d), 70'(d_timeout[d]), 70'(m_terr[d]));
    if (s.rst) begin
      model_reset(d);
      return;
    end
    if (sel < 0) return;
    rq  = (sel == 1) ? rq1 : rq0;
    idx = int'(a[13:2]);
    if (!rq) begin
      m_own[d] = -1; m_wcnt[d] = 0;
    end else if (!s.stall) begin
      if (rd) begin
        check($sformatf("dut%0d m0_readdata", d), 70'(d_m0_readdata[d]), 70'(m_mem[d][idx]));
        check($sformatf("dut%0d m1_readdata", d), 70'(d_m1_readdata[d]), 70'(m_mem[d][idx]));
      end
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
      m_own[d] = -1; m_last[d] = sel; m_wcnt[d] = 0;
    end else begin
      m_own[d] = sel;
      if (m_wcnt[d] < to_of(d)) m_wcnt[d]++;
      if (m_wcnt[d] >= to_of(d)) m_terr[d] = 1'b1;
    end
  endtask

  // Drive one cycle at the falling edge, then compare both instances.
  task automatic apply_cycle(stim_t s);
    @(negedge clk);
    reset = s.rst;
    m0_read = s.r0; m0_write = s.w0; m0_address = s.a0; m0_writedata = s.d0; m0_byteenable = s.be0;
    m1_read = s.r1; m1_write = s.w1; m1_address = s.a1; m1_writedata = s.d1; m1_byteenable = s.be1;
    s_waitrequest = s.stall;
    #1;
    model_cycle(0, s);
    model_cycle(1, s);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit       rst, r0, r1, stall;
    bit [1:0] ga;        // dut0 grant
    bit       wa0, wa1;  // dut0 waitrequests
    bit [1:0] gb;        // dut1 grant
    bit       ta;        // dut0 timeout_err
  } vec_t;

  localparam logic [31:0] A_BOOT = 32'hBFC00000;
  localparam logic [31:0] A_M1   = 32'h00000010;
  localparam logic [31:0] A_WR   = 32'h00001000;

  initial begin
    vec_t        tbl [15];
    stim_t       s;
    logic [31:0] w;
    int          op;

    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      for (int i = 0; i < 4096; i++) begin
        ram[d][i]   = seed(i);
        m_mem[d][i] = seed(i);
      end
    end

    //          rst r0 r1 st  ga    wa0 wa1 gb    ta
    tbl[0]  = '{1, 1, 0, 0, 2'b00, 1, 1, 2'b00, 0};  // reset with m0_read held
    tbl[1]  = '{1, 1, 0, 0, 2'b00, 1, 1, 2'b00, 0};
    tbl[2]  = '{0, 1, 0, 0, 2'b01, 0, 1, 2'b01, 0};  // first cycle after reset
    tbl[3]  = '{0, 1, 1, 1, 2'b10, 1, 1, 2'b01, 0};  // RR: M0 served last -> M1
    tbl[4]  = '{0, 1, 1, 1, 2'b10, 1, 1, 2'b01, 0};
    tbl[5]  = '{0, 1, 1, 0, 2'b10, 1, 0, 2'b01, 0};
    tbl[6]  = '{0, 1, 1, 1, 2'b01, 1, 1, 2'b01, 0};  // stall 1
    tbl[7]  = '{0, 1, 1, 1, 2'b01, 1, 1, 2'b01, 0};  // stall 2
    tbl[8]  = '{0, 1, 1, 1, 2'b01, 1, 1, 2'b01, 0};  // stall 3
    tbl[9]  = '{0, 1, 1, 1, 2'b01, 1, 1, 2'b01, 0};  // stall 4
    tbl[10] = '{0, 1, 1, 0, 2'b01, 0, 1, 2'b01, 1};  // timeout visible
    tbl[11] = '{0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 1};  // sticky
    tbl[12] = '{1, 0, 0, 0, 2'b00, 1, 1, 2'b00, 1};
    tbl[13] = '{0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 0};  // cleared by reset
    tbl[14] = '{0, 0, 1, 0, 2'b10, 1, 0, 2'b10, 0};

    for (int i = 0; i < 15; i++) begin
      apply_cycle(mk(tbl[i].rst, tbl[i].r0, 1'b0, A_BOOT, '0, 4'hF,
                     tbl[i].r1, 1'b0, A_M1, '0, 4'hF, tbl[i].stall));
      check($sformatf("vec%0d dut0 grant", i), 70'(d_grant[0]), 70'(tbl[i].ga));
      check($sformatf("vec%0d dut0 m0_wait", i), 70'(d_m0_wait[0]), 70'(tbl[i].wa0));
      check($sformatf("vec%0d dut0 m1_wait", i), 70'(d_m1_wait[0]), 70'(tbl[i].wa1));
      check($sformatf("vec%0d dut1 grant", i), 70'(d_grant[1]), 70'(tbl[i].gb));
      check($sformatf("vec%0d dut0 timeout", i), 70'(d_timeout[0]), 70'(tbl[i].ta));
    end

    // Zero-wait boot read completes in one cycle and leaves the arbiter idle.
    apply_cycle(mk(1, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    apply_cycle(mk(0, 1, 0, A_BOOT, '0, 4'hF, 0, 0, '0, '0, 4'h0, 0));
    check("boot read data", 70'(d_m0_readdata[0]), 70'(seed(0)));
    check("boot read wait", 70'(d_m0_wait[0]), 70'(1'b0));
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    check("idle after boot read", 70'(d_grant[0]), 70'(2'b00));

    // Round-robin with a 2-cycle RAM stall: M0, M1, M0, three cycles each.
    apply_cycle(mk(1, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 3; c++) begin
        apply_cycle(mk(0, 1, 0, A_BOOT, '0, 4'hF, 1, 0, A_M1, '0, 4'hF, c < 2));
        check($sformatf("rr xfer%0d cyc%0d grant", t, c), 70'(d_grant[0]),
              70'((t == 1) ? 2'b10 : 2'b01));
        check($sformatf("rr xfer%0d cyc%0d loser wait", t, c),
              70'((t == 1) ? d_m0_wait[0] : d_m1_wait[0]), 70'(1'b1));
        check($sformatf("fp xfer%0d cyc%0d grant", t, c), 70'(d_grant[1]), 70'(2'b01));
      end
    end

    // M1 partial write, then read back the merged word.
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 0, 1, A_WR, 32'hDEADBEEF, 4'b0011, 0));
    check("m1 write bus", {d_s_read[0], d_s_write[0], d_s_be[0], d_s_address[0], d_s_writedata[0]},
          {1'b0, 1'b1, 4'b0011, A_WR, 32'hDEADBEEF});
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 1, 0, A_WR, '0, 4'hF, 0));
    w = seed(int'(A_WR[13:2]));
    check("m1 readback", 70'(d_m1_readdata[0]), 70'({w[31:16], 16'hBEEF}));

    // Ten stall cycles with TIMEOUT_CYCLES=4 on dut0.
    apply_cycle(mk(1, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    for (int i = 0; i < 11; i++) begin
      apply_cycle(mk(0, 1, 0, A_BOOT, '0, 4'hF, 0, 0, '0, '0, 4'h0, i < 10));
      check($sformatf("timeout cyc%0d", i), 70'(d_timeout[0]), 70'(i >= 4));
    end
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    check("timeout sticky", 70'(d_timeout[0]), 70'(1'b1));
    apply_cycle(mk(1, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    apply_cycle(mk(0, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, 0));
    check("timeout cleared", 70'(d_timeout[0]), 70'(1'b0));

    // Random traffic against the model, including strobe drops and resets.
    for (int n = 0; n < 3000; n++) begin
      s.rst = ($urandom_range(0, 149) == 0);
      op = $urandom_range(0, 3);
      s.r0 = (op == 1) || (op == 2);
      s.w0 = (op == 3);
      op = $urandom_range(0, 3);
      s.r1 = (op == 1) || (op == 2);
      s.w1 = (op == 3);
      s.a0 = 32'($urandom_range(0, 15)) << 2;
      s.a1 = 32'($urandom_range(0, 15)) << 2;
      s.d0 = $urandom;
      s.d1 = $urandom;
      s.be0 = 4'($urandom_range(0, 15));
      s.be1 = 4'($urandom_range(0, 15));
      s.stall = ($urandom_range(0, 9) < 4);
      apply_cycle(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
